// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scanner.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode pattern for a digit index; an[0] is the rightmost digit.
    function automatic logic [3:0] an_decode(input logic [1:0] idx);
        logic [3:0] an_v;
        case (idx)
            2'd0:    an_v = 4'b1110;
            2'd1:    an_v = 4'b1101;
            2'd2:    an_v = 4'b1011;
            2'd3:    an_v = 4'b0111;
            default: an_v = AN_OFF;
        endcase
        return an_v;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 render as a dash so a bad digit is visible rather than silent.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  digit_t digit_i,
    output seg_t   seg_o
);

    // Map each BCD code to its segment pattern; anything out of range is a dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digits are captured into a shadow register on load, then shown one at a
// time for REFRESH_DIV clocks each. Outputs are registered, so they follow
// the index/shadow state one clock later. Optional leading-zero blanking
// turns off segments (but not the anode) of zero digits left of the first
// nonzero digit; the rightmost digit is always shown.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int          LZB         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int                 CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    digit_t [3:0]     shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    seg_t             seg_q, seg_d;

    logic             tick_s;
    digit_t           cur_digit_s;
    seg_t             dec_seg_s;
    logic [3:0]       lead_zero_s;
    logic             blank_lead_s;

    // Refresh counter, digit index and shadow capture next-state.
    always_comb begin
        tick_s   = (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
        if (load) begin
            shadow_d = {bcd3, bcd2, bcd1, bcd0};
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Select the digit under the current index for the decoder.
    always_comb begin
        cur_digit_s = shadow_q[idx_q];
    end

    bcd_to_seg7 u_dec (
        .digit_i (cur_digit_s),
        .seg_o   (dec_seg_s)
    );

    // Leading-zero detection: a digit blanks only if it and all digits to its
    // left are zero. Invalid codes are nonzero, so they always stop blanking.
    always_comb begin
        lead_zero_s    = 4'b0000;
        lead_zero_s[3] = (shadow_q[3] == 4'h0);
        lead_zero_s[2] = lead_zero_s[3] && (shadow_q[2] == 4'h0);
        lead_zero_s[1] = lead_zero_s[2] && (shadow_q[1] == 4'h0);
        lead_zero_s[0] = 1'b0;
        blank_lead_s   = (LZB != 0) && lead_zero_s[idx_q];
    end

    // Output next-state: global blank wins, then leading-zero blank, then the decoded digit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end else begin
            an_d = an_decode(idx_q);
            if (blank_lead_s) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = dec_seg_s;
            end
        end
    end

    // State and output registers; reset forces display off and clears all state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= {CNT_W{1'b0}};
            idx_q    <= 2'd0;
            shadow_q <= {4{4'h0}};
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with REFRESH_DIV=4, LZB=1.
// The stimulus process drives inputs and pushes the hand-derived expected
// {an,seg} for each upcoming sample; the monitor pops and compares on the
// falling edge.
module tb_seg7_scan;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;

    seg7_scan #(
        .REFRESH_DIV (4),
        .LZB         (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .bcd3  (bcd3),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .blank (blank),
        .an    (an),
        .seg   (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Active-low anode per digit index (digit 0 is rightmost).
    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Expected segments per digit for the current shadow contents, and for a pending load.
    logic [6:0] cur_exp [4];
    logic [6:0] pend_exp[4];
    int         edges = 0;

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (an !== mon_e.an || seg !== mon_e.seg) begin
                n_fail++;
                $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h (t=%0t)",
                         mon_e.name, an, seg, mon_e.an, mon_e.seg, $time);
            end
            n_checks++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL %s_onehot: got an=%b, expected at most one low bit",
                         mon_e.name, an);
            end
        end
    end

    // One clock: snapshot the inputs the DUT samples, wait for the edge, queue the expectation.
    task automatic step(input string name);
        logic r, b, l;
        int   d;
        r = rst;
        b = blank;
        l = load;
        @(posedge clk);
        #1;
        if (!r) begin
            edges = 0;
            sb_q.push_back('{4'b1111, 7'h7F, name});
            cur_exp = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        end else begin
            edges++;
            d = ((edges - 1) / 4) % 4;
            if (b) begin
                sb_q.push_back('{4'b1111, 7'h7F, name});
            end else begin
                sb_q.push_back('{an_tab[d], cur_exp[d], name});
            end
            if (l) begin
                cur_exp = pend_exp;
            end
        end
        if (l) begin
            load = 1'b0;
            // Inputs must be ignored once load drops.
            bcd3 = 4'h7; bcd2 = 4'h7; bcd1 = 4'h7; bcd0 = 4'h7;
        end
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            step(name);
        end
    endtask

    // Present a load for the next edge with hand-computed per-digit segments e0 (rightmost)..e3.
    task automatic do_load(input logic [3:0] b3, input logic [3:0] b2,
                           input logic [3:0] b1, input logic [3:0] b0,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
        bcd3 = b3; bcd2 = b2; bcd1 = b1; bcd0 = b0;
        load = 1'b1;
        pend_exp = '{e0, e1, e2, e3};
    endtask

    // Assert reset just after a rising edge; the sample half a cycle later must already be off.
    task automatic reset_step(input string name);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        load = 1'b0;
        sb_q.push_back('{4'b1111, 7'h7F, name});
        edges = 0;
        cur_exp = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        blank = 1'b0;
        bcd3 = 4'h0; bcd2 = 4'h0; bcd1 = 4'h0; bcd0 = 4'h0;
        cur_exp  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        pend_exp = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        repeat (2) @(posedge clk);

        // Reset and first scan after release
        reset_step("rst_async");
        run(2, "rst_hold");
        rst = 1'b1;
        run(16, "post_rst");

        // Leading zeros blanked, 3 on digit 0 and 5 on digit 1
        do_load(4'h0, 4'h0, 4'h5, 4'h3, 7'h30, 7'h12, 7'h7F, 7'h7F);
        run(20, "load_0053");

        // Interior zero digit 0 shown, higher zero blanked
        do_load(4'h0, 4'h1, 4'h2, 4'h0, 7'h40, 7'h24, 7'h79, 7'h7F);
        run(18, "load_0120");

        // Invalid code renders as a dash
        do_load(4'h0, 4'h0, 4'hC, 4'h0, 7'h40, 7'h3F, 7'h7F, 7'h7F);
        run(18, "load_00C0");

        // Global blank mid-scan; index keeps running underneath
        run(3, "pre_blank");
        blank = 1'b1;
        run(6, "blank_on");
        blank = 1'b0;
        run(12, "blank_off");

        // Load coinciding with a refresh tick
        while (edges % 4 != 3) begin
            step("align");
        end
        do_load(4'h9, 4'h8, 4'h7, 4'h6, 7'h02, 7'h78, 7'h00, 7'h10);
        run(17, "load_tick");

        // Reset mid-scan while a load is pending
        run(5, "pre_rst_mid");
        do_load(4'h1, 4'h2, 4'h3, 4'h4, 7'h19, 7'h30, 7'h24, 7'h79);
        reset_step("rst_mid");
        run(2, "rst_mid_hold");
        rst = 1'b1;
        run(16, "rst_release");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
